// File: rtl/yuv2rgb_sum_clamp.sv
// Two-stage YUV->RGB back end: sums multiplier products, rounds, shifts and clamps to 8 bits.
// Also flags the last pixel of each frame and counts the pixels that needed clamping.
module yuv2rgb_sum_clamp #(
    parameter int unsigned FRAME_PIXELS = 64,
    parameter int unsigned FRAC_BITS    = 7
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_y,
    input  logic [15:0] in_rv,
    input  logic [15:0] in_gu,
    input  logic [15:0] in_gv,
    input  logic [15:0] in_bu,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_r,
    output logic [7:0]  out_g,
    output logic [7:0]  out_b,
    output logic        out_last,
    input  logic        sat_clr,
    output logic [15:0] sat_count
);

    localparam logic signed [17:0] RND      = 18'sd1 <<< (FRAC_BITS - 1);
    localparam logic [15:0]        LAST_IDX = 16'(FRAME_PIXELS - 1);

    logic               en;
    logic               s1_valid;
    logic signed [17:0] s1_r;
    logic signed [17:0] s1_g;
    logic signed [17:0] s1_b;
    logic [15:0]        pix_cnt;
    logic [8:0]         cl_r;
    logic [8:0]         cl_g;
    logic [8:0]         cl_b;
    logic               any_clamp;

    function automatic logic signed [17:0] sext(input logic [15:0] v);
        return $signed({{2{v[15]}}, v});
    endfunction

    // Result is {clamped flag, channel value}.
    function automatic logic [8:0] clamp(input logic signed [17:0] s);
        logic signed [17:0] sh;
        sh = s >>> FRAC_BITS;
        if (sh[17])
            return {1'b1, 8'd0};
        else if (sh > 18'sd255)
            return {1'b1, 8'd255};
        else
            return {1'b0, sh[7:0]};
    endfunction

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign out_last = out_valid && (pix_cnt == LAST_IDX);

    always_comb begin
        cl_r      = clamp(s1_r);
        cl_g      = clamp(s1_g);
        cl_b      = clamp(s1_b);
        any_clamp = cl_r[8] || cl_g[8] || cl_b[8];
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s1_valid  <= 1'b0;
            s1_r      <= '0;
            s1_g      <= '0;
            s1_b      <= '0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_r      <= sext(in_y) + sext(in_rv) + RND;
            s1_g      <= sext(in_y) - sext(in_gu) - sext(in_gv) + RND;
            s1_b      <= sext(in_y) + sext(in_bu) + RND;
            out_valid <= s1_valid;
            out_r     <= cl_r[7:0];
            out_g     <= cl_g[7:0];
            out_b     <= cl_b[7:0];
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst)
            pix_cnt <= '0;
        else if (out_valid && out_ready)
            pix_cnt <= (pix_cnt == LAST_IDX) ? '0 : pix_cnt + 16'd1;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst)
            sat_count <= '0;
        else if (sat_clr)
            sat_count <= '0;
        else if (en && s1_valid && any_clamp && (sat_count != '1))
            sat_count <= sat_count + 16'd1;
    end

endmodule

// File: tb/tb_yuv2rgb_sum_clamp.sv
// Scoreboard bench for yuv2rgb_sum_clamp: expected pixels are queued on input acceptance
// and compared when the DUT hands them out.
module tb_yuv2rgb_sum_clamp;

    localparam int FP = 4;
    localparam int FB = 7;

    typedef struct {
        int r;
        int g;
        int b;
        bit last;
        bit sat;
    } exp_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_y = '0, in_rv = '0, in_gu = '0, in_gv = '0, in_bu = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_r, out_g, out_b;
    logic        out_last;
    logic        sat_clr = 1'b0;
    logic [15:0] sat_count;

    int   total = 0;
    int   passed = 0;
    int   failed = 0;
    int   idx = 0;
    int   sat_exp = 0;
    bit   track = 1'b1;
    bit   mon_en = 1'b1;
    exp_t q[$];

    yuv2rgb_sum_clamp #(.FRAME_PIXELS(FP), .FRAC_BITS(FB)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_y(in_y), .in_rv(in_rv), .in_gu(in_gu), .in_gv(in_gv), .in_bu(in_bu),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_last(out_last),
        .sat_clr(sat_clr), .sat_count(sat_count)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // floor(s / 2^FB) then clamp to 0..255
    function automatic int chan(input int s, inout bit sat);
        int d = 1 << FB;
        int v = s / d;
        if ((s % d) != 0 && s < 0) v = v - 1;
        if (v < 0) begin sat = 1'b1; return 0; end
        if (v > 255) begin sat = 1'b1; return 255; end
        return v;
    endfunction

    task automatic send(input int y, input int rv, input int gu, input int gv, input int bu);
        exp_t e;
        int n = 0;
        in_valid = 1'b1;
        in_y = 16'(y); in_rv = 16'(rv); in_gu = 16'(gu); in_gv = 16'(gv); in_bu = 16'(bu);
        @(negedge ap_clk);
        while (!in_ready && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        if (n >= 50) begin
            chk("accept_timeout", n, 0);
        end else begin
            e.sat  = 1'b0;
            e.r    = chan(y + rv + (1 << (FB - 1)), e.sat);
            e.g    = chan(y - gu - gv + (1 << (FB - 1)), e.sat);
            e.b    = chan(y + bu + (1 << (FB - 1)), e.sat);
            e.last = (idx == FP - 1);
            idx    = (idx + 1) % FP;
            if (e.sat && sat_exp < 65535) sat_exp++;
            if (track) q.push_back(e);
        end
        @(posedge ap_clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(posedge ap_clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        repeat (3) @(posedge ap_clk);
        #1;
    endtask

    task automatic pulse_reset();
        ap_rst = 1'b1;
        q.delete();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_ready", in_ready, 1);
        ap_rst  = 1'b0;
        idx     = 0;
        sat_exp = 0;
    endtask

    always @(negedge ap_clk) begin
        if (mon_en && out_valid && out_ready) begin
            chk("queue_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("out_r", out_r, e.r);
                chk("out_g", out_g, e.g);
                chk("out_b", out_b, e.b);
                chk("out_last", out_last, e.last);
            end
        end
    end

    initial begin
        #3;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_sat_count", sat_count, 0);
        chk("reset_out_r", out_r, 0);
        chk("reset_out_last", out_last, 0);
        #9 ap_rst = 1'b0;
        @(posedge ap_clk);
        #1;

        // nominal grey
        send(12800, 0, 0, 0, 0);
        drain();
        chk("sat_nominal", sat_count, sat_exp);

        // clamp high and low
        send(16384, 16384, 0, 0, 0);
        send(-1000, 0, 0, 0, 0);
        drain();
        chk("sat_after_clamps", sat_count, 2);

        // mixed patterns back to back
        for (int i = 0; i < 8; i++)
            send(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
                 int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
                 int'($urandom_range(65535)) - 32768);
        send(32767, 32767, -32768, -32768, 32767);
        send(-32768, -32768, 32767, 32767, -32768);
        send(127, 0, 0, 0, 0);
        drain();
        chk("sat_mixed", sat_count, sat_exp);

        // backpressure: 4 pixels, output stalled for 5 cycles
        out_ready = 1'b0;
        fork
            for (int k = 1; k <= 4; k++) send(1280 * k, 0, 0, 0, 0);
            begin
                repeat (3) @(posedge ap_clk);
                #2 chk("in_ready_stall", in_ready, 0);
                repeat (2) @(posedge ap_clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // framing from a fresh reset
        pulse_reset();
        for (int k = 0; k < 9; k++) send(256 * k, 0, 0, 0, 0);
        drain();
        chk("pix_cnt_end", 32'(dut.pix_cnt), 1);

        // async reset with two pixels in flight
        send(2560, 0, 0, 0, 0);
        send(5120, 0, 0, 0, 0);
        pulse_reset();
        chk("sat_after_reset", sat_count, 0);
        repeat (4) @(posedge ap_clk);
        #1;
        for (int k = 0; k < FP; k++) send(1000 * k, 200, 100, 100, 300);
        drain();

        // saturating counter
        track  = 1'b0;
        mon_en = 1'b0;
        for (int k = 0; k < 65535; k++) send(16384, 16384, 0, 0, 0);
        repeat (4) @(posedge ap_clk);
        #1;
        mon_en = 1'b1;
        track  = 1'b1;
        chk("sat_full", sat_count, sat_exp);
        send(-2000, 0, 0, 0, 0);
        drain();
        chk("sat_hold", sat_count, 65535);
        send(16384, 16384, 0, 0, 0);
        sat_clr = 1'b1;
        @(posedge ap_clk);
        #1 sat_clr = 1'b0;
        sat_exp = 0;
        drain();
        chk("sat_clr_priority", sat_count, sat_exp);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
